// File: rtl/adc_tx_top.sv
// rtl/adc_tx_top.sv - push-button SPI ADC sampler with two-byte UART readout
// Define PARITY_EN to add an even-parity bit to each UART frame (8E1); default is 8N1.
module adc_tx_top #(
  parameter int                  CLK_HALF = 20,
  parameter int                  SPI_BITS = 16,
  parameter logic [SPI_BITS-1:0] SPI_CMD  = 16'hD000,
  parameter int                  BAUD_DIV = 10416
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  input  logic miso_i,
  output logic mosi_o,
  output logic dclk_o,
  output logic cs_o,
  output logic tx_o,
  output logic eos_o
);

`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {IDLE, SPI, TX_HI, TX_LO, DONE} state_t;

  state_t                state, state_nxt;
  logic                  button_q;
  logic [15:0]           div_cnt;
  logic [4:0]            bit_cnt;
  logic [SPI_BITS-1:0]   cmd_sh;
  logic [11:0]           rx_sh;
  logic [11:0]           result;
  logic [FRAME_BITS-2:0] tx_sh;
  logic                  start, half_tick, baud_tick, spi_last, frame_last;
  logic [7:0]            tx_byte;

  // Bits of a frame after the start bit, sent LSB first.
  function automatic logic [FRAME_BITS-2:0] frame_tail(input logic [7:0] b);
`ifdef PARITY_EN
    return {1'b1, ^b, b};
`else
    return {1'b1, b};
`endif
  endfunction

  assign start      = button_i & ~button_q;
  assign half_tick  = (div_cnt == 16'(CLK_HALF - 1));
  assign baud_tick  = (div_cnt == 16'(BAUD_DIV - 1));
  assign spi_last   = half_tick & dclk_o & (bit_cnt == 5'(SPI_BITS - 1));
  assign frame_last = baud_tick & (bit_cnt == 5'(FRAME_BITS - 1));
  assign tx_byte    = (state == TX_HI) ? {4'h0, result[11:8]} : result[7:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = SPI;
      SPI:     if (spi_last)   state_nxt = TX_HI;
      TX_HI:   if (frame_last) state_nxt = TX_LO;
      TX_LO:   if (frame_last) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      button_q <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      cmd_sh   <= '0;
      rx_sh    <= '0;
      result   <= '0;
      tx_sh    <= '0;
      cs_o     <= 1'b1;
      dclk_o   <= 1'b0;
      mosi_o   <= 1'b0;
      tx_o     <= 1'b1;
      eos_o    <= 1'b0;
    end else begin
      button_q <= button_i;
      eos_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cs_o    <= 1'b0;
            mosi_o  <= SPI_CMD[SPI_BITS-1];
            cmd_sh  <= {SPI_CMD[SPI_BITS-2:0], 1'b0};
            div_cnt <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end
        end
        SPI: begin
          if (!half_tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            // Only the low 12 bits are kept; leading frame bits shift out the top.
            if (!dclk_o) begin
              dclk_o <= 1'b1;
              rx_sh  <= {rx_sh[10:0], miso_i};
            end else if (bit_cnt == 5'(SPI_BITS - 1)) begin
              dclk_o  <= 1'b0;
              cs_o    <= 1'b1;
              mosi_o  <= 1'b0;
              bit_cnt <= '0;
              result  <= rx_sh;
              tx_o    <= 1'b0;
            end else begin
              dclk_o  <= 1'b0;
              mosi_o  <= cmd_sh[SPI_BITS-1];
              cmd_sh  <= {cmd_sh[SPI_BITS-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        TX_HI, TX_LO: begin
          if (!baud_tick) begin
            div_cnt <= div_cnt + 1'b1;
            // Payload is loaded during the start bit, once result is stable.
            if (bit_cnt == 5'd0) tx_sh <= frame_tail(tx_byte);
          end else begin
            div_cnt <= '0;
            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
              bit_cnt <= '0;
              tx_o    <= (state == TX_HI) ? 1'b0 : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= tx_sh[0];
              tx_sh   <= {1'b1, tx_sh[FRAME_BITS-2:1]};
            end
          end
        end
        DONE:    eos_o <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_tx_top.sv
// tb/tb_adc_tx_top.sv - directed/random bench for adc_tx_top against a frame-level model
// Honours PARITY_EN the same way as the design.
module tb_adc_tx_top;
  localparam int B    = 16;
  localparam int HALF = 20;
  localparam int SPI_CLKS = 2 * 16 * HALF;
`ifdef PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic clk_i = 1'b0, rst_i = 1'b0, button_i = 1'b0, miso_i = 1'b0;
  logic mosi_o, dclk_o, cs_o, tx_o, eos_o;
  int   checks = 0, failures = 0;
  logic tx_a  [4000];
  logic eos_a [4000];

  always #5 clk_i = ~clk_i;

  adc_tx_top #(.BAUD_DIV(B)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .button_i(button_i), .miso_i(miso_i),
    .mosi_o(mosi_o), .dclk_o(dclk_o), .cs_o(cs_o), .tx_o(tx_o), .eos_o(eos_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one window of ncyc clocks: button high for cycles [0,hold) and [press2,press2+4),
  // ADC returns 'word' MSB first, changing on dclk falling edges.
  task automatic run_seq(input string tag, input logic [15:0] word, input int hold,
                         input int press2, input int ncyc);
    int rises = 0, cs_low = 0, bit_i = 0, eos_hi = 0, eos_pulses = 0, eos_first = -1;
    int st = -1, base, exp_t, diff;
    logic prev_dclk = 1'b0, prev_eos = 1'b0, stable = 1'b1, idle_ok = 1'b1;
    logic [15:0] mosi_w = '0;
    logic [F-1:0] fr [2];
    logic [7:0] exp_b [2];
    exp_b[0] = {4'h0, word[11:8]};
    exp_b[1] = word[7:0];
    miso_i = word[15];
    for (int c = 0; c < ncyc; c++) begin
      button_i = (c < hold) || (press2 >= 0 && c >= press2 && c < press2 + 4);
      @(negedge clk_i);
      tx_a[c]  = tx_o;
      eos_a[c] = eos_o;
      if (!cs_o) cs_low++;
      if (dclk_o && !prev_dclk) begin
        rises++;
        mosi_w = {mosi_w[14:0], mosi_o};
      end
      if (!dclk_o && prev_dclk && bit_i < 15) begin
        bit_i++;
        miso_i = word[15 - bit_i];
      end
      prev_dclk = dclk_o;
      if (eos_o) begin
        eos_hi++;
        if (eos_first < 0) eos_first = c;
      end
      if (eos_o && !prev_eos) eos_pulses++;
      prev_eos = eos_o;
    end
    button_i = 1'b0;
    for (int c = 0; c < ncyc; c++)
      if (st < 0 && tx_a[c] === 1'b0) st = c;
    check({tag, ":tx_start_found"}, 32'(st >= 0 && st + 2 * F * B < ncyc), 1);
    if (st < 0) st = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < F; i++) begin
        base = st + (f * F + i) * B;
        fr[f][i] = (base < ncyc) ? tx_a[base] : 1'bx;
        for (int k = 0; k < B; k++)
          if (base + k >= ncyc || tx_a[base + k] !== fr[f][i]) stable = 1'b0;
      end
    for (int c = st + 2 * F * B; c < ncyc; c++)
      if (tx_a[c] !== 1'b1) idle_ok = 1'b0;
    check({tag, ":cs_low_clocks"}, 32'(cs_low), SPI_CLKS);
    check({tag, ":dclk_rises"}, 32'(rises), 16);
    check({tag, ":mosi_word"}, 32'(mosi_w), 32'h0000_D000);
    for (int f = 0; f < 2; f++) begin
      check({tag, ":start_bit"}, 32'(fr[f][0]), 0);
      check({tag, ":data_byte"}, 32'(fr[f][8:1]), 32'(exp_b[f]));
`ifdef PARITY_EN
      check({tag, ":parity_bit"}, 32'(fr[f][9]), 32'(^exp_b[f]));
`endif
      check({tag, ":stop_bit"}, 32'(fr[f][F-1]), 1);
    end
    check({tag, ":bit_width_exact"}, 32'(stable), 1);
    check({tag, ":tx_idle_after"}, 32'(idle_ok), 1);
    check({tag, ":eos_pulses"}, 32'(eos_pulses), 1);
    check({tag, ":eos_width"}, 32'(eos_hi), 1);
    exp_t = 1 + SPI_CLKS + 2 * F * B;
    diff  = eos_first - exp_t;
    check({tag, ":eos_timing"}, 32'(diff >= -2 && diff <= 2), 1);
  endtask

  initial begin
    int ev, txz, csz;
    repeat (2) @(negedge clk_i);
    check("rst:cs", 32'(cs_o), 1);
    check("rst:dclk", 32'(dclk_o), 0);
    check("rst:mosi", 32'(mosi_o), 0);
    check("rst:tx", 32'(tx_o), 1);
    check("rst:eos", 32'(eos_o), 0);
    rst_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("idle:cs", 32'(cs_o), 1);
    check("idle:dclk", 32'(dclk_o), 0);
    check("idle:tx", 32'(tx_o), 1);
    check("idle:eos", 32'(eos_o), 0);

    run_seq("ones", 16'hFFFF, 1, -1, 1200);
    run_seq("pat0A5C", 16'h0A5C, 1, -1, 1200);
    for (int r = 0; r < 3; r++)
      run_seq("rand", 16'($urandom), 1 + $urandom_range(0, 5), -1, 1200);
    run_seq("held", 16'($urandom), 1000, -1, 1400);
    run_seq("press_in_tx", 16'($urandom), 1, 2 * HALF * 16 + 3 * B, 1400);

    button_i = 1'b1;
    @(negedge clk_i);
    button_i = 1'b0;
    repeat (299) @(negedge clk_i);
    check("midrst:cs_before", 32'(cs_o), 0);
    #3 rst_i = 1'b0;
    #1;
    check("midrst:cs", 32'(cs_o), 1);
    check("midrst:dclk", 32'(dclk_o), 0);
    check("midrst:tx", 32'(tx_o), 1);
    check("midrst:eos", 32'(eos_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    ev = 0; txz = 0; csz = 0;
    repeat (1200) begin
      @(negedge clk_i);
      if (eos_o) ev++;
      if (!tx_o) txz++;
      if (!cs_o) csz++;
    end
    check("midrst:eos_after", 32'(ev), 0);
    check("midrst:tx_low_after", 32'(txz), 0);
    check("midrst:cs_low_after", 32'(csz), 0);
    run_seq("after_rst", 16'($urandom), 1, -1, 1200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
